axis_stream_checker: RTL

- Downstream scoreboard stage for the stimulus exerciser. The exerciser pushes expected AXI-Stream beats into this block.
- The block consumes the DUT's output AXI-Stream and compares it beat-by-beat against the expected beats.
- It reports mismatches, packet completion and timeouts as registered flags that feed the exerciser's per-section error/done vectors.

---
 rtl/axis_checker_pkg.sv | 41 ++++
 rtl/axis_checker_fifo.sv | 68 ++++++
 rtl/axis_stream_checker.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/axis_checker_pkg.sv
// Shared types and constants for the AXI-Stream checker: the expected-beat record,
// the checker state encoding, the backpressure LFSR constants and the beat comparator.
package axis_checker_pkg;

    localparam int unsigned EXP_DATA_WIDTH = 64;
    localparam int unsigned EXP_KEEP_WIDTH = EXP_DATA_WIDTH / 8;

    typedef struct packed {
        logic [EXP_DATA_WIDTH-1:0] data;
        logic [EXP_KEEP_WIDTH-1:0] keep;
        logic                      last;
    } exp_beat_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        TIMEOUT = 2'd2
    } checker_state_e;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] state);
        return {state[14:0], ^(state & LFSR_TAPS)};
    endfunction

    // Keep and last must agree exactly; data is only compared on enabled bytes
    function automatic logic beat_matches(input exp_beat_t               exp_beat,
                                          input logic [EXP_DATA_WIDTH-1:0] data,
                                          input logic [EXP_KEEP_WIDTH-1:0] keep,
                                          input logic                      last);
        logic ok;
        ok = (keep == exp_beat.keep) && (last == exp_beat.last);
        for (int i = 0; i < int'(EXP_KEEP_WIDTH); i++) begin
            ok = ok & ~(exp_beat.keep[i] & (|(data[8*i +: 8] ^ exp_beat.data[8*i +: 8])));
        end
        return ok;
    endfunction

endpackage

// File: rtl/axis_checker_fifo.sv
// Single-clock FIFO of expected beats with a registered head-of-queue output.
// No bypass: a beat written at one edge appears on rd_data from the next cycle on.
module axis_checker_fifo
    import axis_checker_pkg::*;
#(
    parameter int unsigned EXP_DEPTH = 16
) (
    input  logic      clk,
    input  logic      flush,
    input  logic      push,
    input  exp_beat_t wr_data,
    input  logic      pop,
    output exp_beat_t rd_data,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(EXP_DEPTH);

    exp_beat_t       mem_q [EXP_DEPTH];
    exp_beat_t       head_q;
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            push_ok_s;
    logic            pop_ok_s;

    assign full      = (count_q == (AW+1)'(EXP_DEPTH));
    assign empty     = (count_q == '0);
    assign push_ok_s = push && !full && !flush;
    assign pop_ok_s  = pop && !empty && !flush;
    assign rd_data   = head_q;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Pointers, occupancy and head register; head reloads from the write port when it is the next entry
    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (push_ok_s && ((count_q == '0) || ((count_q == (AW+1)'(1)) && pop_ok_s))) begin
                head_q <= wr_data;
            end else if (pop_ok_s) begin
                head_q <= mem_q[rd_ptr_q + AW'(1)];
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axis_stream_checker.sv
// Beat-by-beat scoreboard comparing a DUT AXI-Stream against pushed expected beats.
// Define AXIS_CHECKER_BACKPRESSURE_EN to gate s_axis_tready with a free-running LFSR.
module axis_stream_checker
    import axis_checker_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = EXP_DATA_WIDTH,
    parameter int unsigned KEEP_WIDTH     = DATA_WIDTH / 8,
    parameter int unsigned EXP_DEPTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_WIDTH      = 16
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic                  clear,
    input  logic                  exp_valid,
    output logic                  exp_ready,
    input  logic [DATA_WIDTH-1:0] exp_data,
    input  logic [KEEP_WIDTH-1:0] exp_keep,
    input  logic                  exp_last,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tlast,
    output logic [CNT_WIDTH-1:0]  beat_count,
    output logic [CNT_WIDTH-1:0]  mismatch_count,
    output logic                  error,
    output logic                  timeout,
    output logic                  packet_done,
    output logic                  idle
);

    localparam int unsigned STALL_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(TIMEOUT_CYCLES - 1);

    exp_beat_t          push_beat_s;
    exp_beat_t          head_s;
    logic               flush_s, push_s, full_s, empty_s;
    logic               bp_ok_s, tready_s, hs_s, match_s, stall_s;
    checker_state_e     state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [CNT_WIDTH-1:0] beat_q, mm_q;
    logic               error_q, timeout_q, pdone_q;

    assign flush_s = ap_rst || clear;
    assign push_s  = exp_valid && !full_s;

    always_comb begin
        push_beat_s      = '0;
        push_beat_s.data = EXP_DATA_WIDTH'(exp_data);
        push_beat_s.keep = EXP_KEEP_WIDTH'(exp_keep);
        push_beat_s.last = exp_last;
    end

    axis_checker_fifo #(
        .EXP_DEPTH (EXP_DEPTH)
    ) u_fifo (
        .clk     (ap_clk),
        .flush   (flush_s),
        .push    (push_s),
        .wr_data (push_beat_s),
        .pop     (hs_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s)
    );

`ifdef AXIS_CHECKER_BACKPRESSURE_EN
    logic [15:0] lfsr_q;

    // Free-running backpressure pattern, restarted from the seed on reset or clear
    always_ff @(posedge ap_clk) begin
        if (flush_s) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_next(lfsr_q);
        end
    end

    assign bp_ok_s = lfsr_q[0];
`else
    assign bp_ok_s = 1'b1;
`endif

    assign tready_s = !empty_s && (state_q != TIMEOUT) && bp_ok_s;
    assign hs_s     = s_axis_tvalid && tready_s;
    assign match_s  = beat_matches(head_s, EXP_DATA_WIDTH'(s_axis_tdata),
                                   EXP_KEEP_WIDTH'(s_axis_tkeep), s_axis_tlast);
    // A cycle gated low by the LFSR is the checker's own doing, not a DUT stall
    assign stall_s  = (state_q == CHECK) && !empty_s && bp_ok_s && !hs_s;

    // Next state and stall counter
    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        case (state_q)
            IDLE: begin
                stall_d = '0;
                if (!empty_s) begin
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (stall_s && (stall_q == STALL_LAST)) begin
                    state_d = TIMEOUT;
                end else if (empty_s) begin
                    state_d = IDLE;
                end else begin
                    state_d = CHECK;
                end
                if (hs_s) begin
                    stall_d = '0;
                end else if (stall_s) begin
                    stall_d = stall_q + STALL_W'(1);
                end else begin
                    stall_d = stall_q;
                end
            end
            TIMEOUT: begin
                state_d = TIMEOUT;
                stall_d = '0;
            end
            default: begin
                state_d = IDLE;
                stall_d = '0;
            end
        endcase
    end

    // State, counters and status flags
    always_ff @(posedge ap_clk) begin
        if (flush_s) begin
            state_q   <= IDLE;
            stall_q   <= '0;
            beat_q    <= '0;
            mm_q      <= '0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            pdone_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            pdone_q <= hs_s && s_axis_tlast;
            if (hs_s) begin
                beat_q <= beat_q + CNT_WIDTH'(1);
            end
            if (hs_s && !match_s) begin
                error_q <= 1'b1;
                if (mm_q != {CNT_WIDTH{1'b1}}) begin
                    mm_q <= mm_q + CNT_WIDTH'(1);
                end
            end
            if (state_d == TIMEOUT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign exp_ready      = !full_s;
    assign s_axis_tready  = tready_s;
    assign beat_count     = beat_q;
    assign mismatch_count = mm_q;
    assign error          = error_q;
    assign timeout        = timeout_q;
    assign packet_done    = pdone_q;
    assign idle           = empty_s && (state_q == IDLE);

endmodule
